// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct constants, FSM state encoding and datapath control codes
// shared by the control unit, immediate extender and ALU.
`default_nettype none

package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;

  // Eight multicycle states in the low three bits; HALT alone sets bit 3.
  localparam logic [3:0] ST_IF     = 4'b0000;
  localparam logic [3:0] ST_ID     = 4'b0001;
  localparam logic [3:0] ST_EXE_AL = 4'b0010;
  localparam logic [3:0] ST_EXE_BR = 4'b0011;
  localparam logic [3:0] ST_EXE_LS = 4'b0100;
  localparam logic [3:0] ST_MEM    = 4'b0101;
  localparam logic [3:0] ST_WB_AL  = 4'b0110;
  localparam logic [3:0] ST_WB_LD  = 4'b0111;
  localparam logic [3:0] ST_HALT   = 4'b1000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] EXT_SA   = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_SIGN = 2'b10;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JR     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] DST_RA = 2'b00;
  localparam logic [1:0] DST_RT = 2'b01;
  localparam logic [1:0] DST_RD = 2'b10;

  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic link;
    logic jump_reg;
    logic halt;
    logic nop;
  } ins_class_t;

endpackage

`default_nettype wire

// File: rtl/ins_decode.sv
// ins_decode: combinational op/funct decode into a one-hot instruction class
// plus the state-independent ALU and extender selects.
`default_nettype none

module ins_decode
  import cpu_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output ins_class_t  cls,
  output logic [2:0]  alu_op,
  output logic [1:0]  ext_sel,
  output logic        alu_src_a,
  output logic        alu_src_b
);

  always_comb begin
    cls       = '0;
    alu_op    = ALU_ADD;
    ext_sel   = EXT_SIGN;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: cls.alu_r = 1'b1;
          FUNCT_SUB: begin cls.alu_r = 1'b1; alu_op = ALU_SUB; end
          FUNCT_AND: begin cls.alu_r = 1'b1; alu_op = ALU_AND; end
          FUNCT_OR:  begin cls.alu_r = 1'b1; alu_op = ALU_OR;  end
          FUNCT_SLT: begin cls.alu_r = 1'b1; alu_op = ALU_SLT; end
          FUNCT_SLL: begin
            cls.alu_r = 1'b1;
            alu_op    = ALU_SLL;
            ext_sel   = EXT_SA;
            alu_src_a = 1'b1;
          end
          FUNCT_JR:  cls.jump_reg = 1'b1;
          default:   cls.nop = 1'b1;
        endcase
      end
      OP_ADDI: begin cls.alu_i = 1'b1; alu_src_b = 1'b1; end
      OP_ANDI: begin
        cls.alu_i = 1'b1; alu_src_b = 1'b1; alu_op = ALU_AND; ext_sel = EXT_ZERO;
      end
      OP_ORI: begin
        cls.alu_i = 1'b1; alu_src_b = 1'b1; alu_op = ALU_OR; ext_sel = EXT_ZERO;
      end
      OP_SLTI: begin cls.alu_i = 1'b1; alu_src_b = 1'b1; alu_op = ALU_SLT; end
      OP_LW:   begin cls.load  = 1'b1; alu_src_b = 1'b1; end
      OP_SW:   begin cls.store = 1'b1; alu_src_b = 1'b1; end
      OP_BEQ:  begin cls.branch = 1'b1; alu_op = ALU_SUB; end
      OP_J:    cls.jump = 1'b1;
      OP_JAL:  cls.link = 1'b1;
      OP_HALT: cls.halt = 1'b1;
      default: cls.nop = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// control_unit: multicycle IF/ID/EXE/MEM/WB sequencer driving every datapath
// control line from the current state and the decoded instruction.
`default_nettype none

module control_unit
  import cpu_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic [1:0] ExtSel,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc
);

  logic [3:0]  state;
  logic [3:0]  next_state;
  ins_class_t  cls;
  logic [2:0]  dec_alu_op;
  logic [1:0]  dec_ext_sel;
  logic        dec_src_a;
  logic        dec_src_b;

  ins_decode u_ins_decode (
    .op        (op),
    .funct     (funct),
    .cls       (cls),
    .alu_op    (dec_alu_op),
    .ext_sel   (dec_ext_sel),
    .alu_src_a (dec_src_a),
    .alu_src_b (dec_src_b)
  );

  always_ff @(posedge CLK) begin
    if (Reset) state <= ST_IF;
    else       state <= next_state;
  end

  always_comb begin
    next_state = ST_IF;
    case (state)
      ST_IF: next_state = ST_ID;
      ST_ID: begin
        if (cls.jump || cls.link || cls.jump_reg || cls.nop) next_state = ST_IF;
        else if (cls.halt)                                  next_state = ST_HALT;
        else if (cls.branch)                                next_state = ST_EXE_BR;
        else if (cls.load || cls.store)                     next_state = ST_EXE_LS;
        else                                                next_state = ST_EXE_AL;
      end
      ST_EXE_AL: next_state = ST_WB_AL;
      ST_EXE_BR: next_state = ST_IF;
      ST_EXE_LS: next_state = ST_MEM;
      ST_MEM:    next_state = cls.load ? ST_WB_LD : ST_IF;
      ST_WB_AL:  next_state = ST_IF;
      ST_WB_LD:  next_state = ST_IF;
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_IF;
    endcase
  end

  // Reset forces every output low combinationally, so an abandoned MEM/WB never writes.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    ExtSel    = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = PC_NEXT;
    if (!Reset) begin
      ExtSel  = dec_ext_sel;
      ALUSrcA = dec_src_a;
      ALUSrcB = dec_src_b;
      ALUOp   = dec_alu_op;
      case (state)
        ST_IF: IRWre = 1'b1;
        ST_ID: begin
          if (cls.jump || cls.link || cls.jump_reg || cls.nop) PCWre = 1'b1;
          if (cls.jump || cls.link) PCSrc = PC_JUMP;
          if (cls.jump_reg)         PCSrc = PC_JR;
          if (cls.link) begin
            RegWre = 1'b1;
            RegDst = DST_RA;
          end
        end
        ST_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = zero ? PC_BRANCH : PC_NEXT;
        end
        ST_MEM: begin
          mRD   = cls.load;
          mWR   = cls.store;
          PCWre = cls.store;
        end
        ST_WB_AL: begin
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
          RegDst    = cls.alu_r ? DST_RD : DST_RT;
        end
        ST_WB_LD: begin
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
          DBDataSrc = 1'b1;
          RegDst    = DST_RT;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// tb_control_unit: per-cycle scoreboard of expected control vectors for each
// instruction class, reset behaviour and halt.
`default_nettype none

module tb_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCWre, IRWre, ALUSrcA, ALUSrcB, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [1:0] ExtSel, RegDst, PCSrc;
  logic [2:0] ALUOp;

  control_unit dut (
    .CLK(CLK), .Reset(Reset), .op(op), .funct(funct), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .ExtSel(ExtSel), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR),
    .PCSrc(PCSrc)
  );

  always #5 CLK = ~CLK;

  logic [17:0] obs;
  assign obs = {PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp, RegWre, RegDst,
                WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc};

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [17:0] exp;
  } entry_t;

  entry_t sb[$];
  int errors = 0;
  int checks = 0;

  // ctl fields: {PCWre, IRWre, RegWre, RegDst[1:0], WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc[1:0]}
  localparam logic [10:0] C_IF   = 11'b01_0_00_0_0_0_0_00;
  localparam logic [10:0] C_IDLE = 11'b00_0_00_0_0_0_0_00;
  localparam logic [10:0] C_WBR  = 11'b10_1_10_1_0_0_0_00;
  localparam logic [10:0] C_WBI  = 11'b10_1_01_1_0_0_0_00;
  localparam logic [10:0] C_RD   = 11'b00_0_00_0_0_1_0_00;
  localparam logic [10:0] C_WBLD = 11'b10_1_01_1_1_0_0_00;
  localparam logic [10:0] C_WR   = 11'b10_0_00_0_0_0_1_00;
  localparam logic [10:0] C_PC4  = 11'b10_0_00_0_0_0_0_00;
  localparam logic [10:0] C_BRT  = 11'b10_0_00_0_0_0_0_01;
  localparam logic [10:0] C_JAL  = 11'b10_1_00_0_0_0_0_11;
  localparam logic [10:0] C_JR   = 11'b10_0_00_0_0_0_0_10;
  localparam logic [10:0] C_J    = 11'b10_0_00_0_0_0_0_11;

  // sel fields: {ALUSrcA, ALUSrcB, ALUOp[2:0]}
  localparam logic [4:0] S_ADD = 5'b0_0_000;
  localparam logic [4:0] S_ORI = 5'b0_1_011;
  localparam logic [4:0] S_SLL = 5'b1_0_010;
  localparam logic [4:0] S_LS  = 5'b0_1_000;
  localparam logic [4:0] S_BEQ = 5'b0_0_001;

  function automatic logic [17:0] mk(input logic [1:0] ext, input logic [4:0] sel,
                                     input logic [10:0] ctl);
    return {ctl[10:9], ext, sel, ctl[8:0]};
  endfunction

  task automatic push(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic [1:0] ext, input logic [4:0] sel,
                      input logic [10:0] ctl);
    entry_t e;
    e.rst = r; e.op = o; e.funct = f; e.zero = z; e.exp = mk(ext, sel, ctl);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    entry_t e;
    Reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    push(1'b1, 6'b100011, 6'b0, 1'b0, 2'b00, 5'b0, C_IDLE);
    push(1'b1, 6'b000000, 6'b100000, 1'b1, 2'b00, 5'b0, C_IDLE);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      Reset = e.rst; op = e.op; funct = e.funct; zero = e.zero;
      @(negedge CLK);
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL reset: got %b expected %b", obs, e.exp);
      end
      @(posedge CLK); #1;
    end
    Reset = 1'b0;
  endtask

  task automatic test_alu();
    entry_t e;
    push(1'b0, 6'b000000, 6'b100000, 1'b0, 2'b10, S_ADD, C_IF);
    push(1'b0, 6'b000000, 6'b100000, 1'b0, 2'b10, S_ADD, C_IDLE);
    push(1'b0, 6'b000000, 6'b100000, 1'b0, 2'b10, S_ADD, C_IDLE);
    push(1'b0, 6'b000000, 6'b100000, 1'b0, 2'b10, S_ADD, C_WBR);
    push(1'b0, 6'b001101, 6'b000000, 1'b0, 2'b01, S_ORI, C_IF);
    push(1'b0, 6'b001101, 6'b000000, 1'b0, 2'b01, S_ORI, C_IDLE);
    push(1'b0, 6'b001101, 6'b000000, 1'b0, 2'b01, S_ORI, C_IDLE);
    push(1'b0, 6'b001101, 6'b000000, 1'b0, 2'b01, S_ORI, C_WBI);
    push(1'b0, 6'b000000, 6'b000000, 1'b0, 2'b00, S_SLL, C_IF);
    push(1'b0, 6'b000000, 6'b000000, 1'b0, 2'b00, S_SLL, C_IDLE);
    push(1'b0, 6'b000000, 6'b000000, 1'b0, 2'b00, S_SLL, C_IDLE);
    push(1'b0, 6'b000000, 6'b000000, 1'b0, 2'b00, S_SLL, C_WBR);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      Reset = e.rst; op = e.op; funct = e.funct; zero = e.zero;
      @(negedge CLK);
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL alu op=%b funct=%b: got %b expected %b", e.op, e.funct, obs, e.exp);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load_store();
    entry_t e;
    push(1'b0, 6'b100011, 6'b0, 1'b0, 2'b10, S_LS, C_IF);
    push(1'b0, 6'b100011, 6'b0, 1'b0, 2'b10, S_LS, C_IDLE);
    push(1'b0, 6'b100011, 6'b0, 1'b0, 2'b10, S_LS, C_IDLE);
    push(1'b0, 6'b100011, 6'b0, 1'b0, 2'b10, S_LS, C_RD);
    push(1'b0, 6'b100011, 6'b0, 1'b0, 2'b10, S_LS, C_WBLD);
    push(1'b0, 6'b101011, 6'b0, 1'b0, 2'b10, S_LS, C_IF);
    push(1'b0, 6'b101011, 6'b0, 1'b0, 2'b10, S_LS, C_IDLE);
    push(1'b0, 6'b101011, 6'b0, 1'b0, 2'b10, S_LS, C_IDLE);
    push(1'b0, 6'b101011, 6'b0, 1'b0, 2'b10, S_LS, C_WR);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      Reset = e.rst; op = e.op; funct = e.funct; zero = e.zero;
      @(negedge CLK);
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL load_store op=%b: got %b expected %b", e.op, obs, e.exp);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_beq();
    entry_t e;
    // zero toggles outside EXE_BR to show only the EXE_BR value matters.
    push(1'b0, 6'b000100, 6'b0, 1'b0, 2'b10, S_BEQ, C_IF);
    push(1'b0, 6'b000100, 6'b0, 1'b0, 2'b10, S_BEQ, C_IDLE);
    push(1'b0, 6'b000100, 6'b0, 1'b1, 2'b10, S_BEQ, C_BRT);
    push(1'b0, 6'b000100, 6'b0, 1'b1, 2'b10, S_BEQ, C_IF);
    push(1'b0, 6'b000100, 6'b0, 1'b1, 2'b10, S_BEQ, C_IDLE);
    push(1'b0, 6'b000100, 6'b0, 1'b0, 2'b10, S_BEQ, C_PC4);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      Reset = e.rst; op = e.op; funct = e.funct; zero = e.zero;
      @(negedge CLK);
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL beq zero=%b: got %b expected %b", e.zero, obs, e.exp);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_jumps();
    entry_t e;
    push(1'b0, 6'b000011, 6'b0, 1'b0, 2'b10, S_ADD, C_IF);
    push(1'b0, 6'b000011, 6'b0, 1'b0, 2'b10, S_ADD, C_JAL);
    push(1'b0, 6'b000000, 6'b001000, 1'b0, 2'b10, S_ADD, C_IF);
    push(1'b0, 6'b000000, 6'b001000, 1'b0, 2'b10, S_ADD, C_JR);
    push(1'b0, 6'b000010, 6'b0, 1'b0, 2'b10, S_ADD, C_IF);
    push(1'b0, 6'b000010, 6'b0, 1'b0, 2'b10, S_ADD, C_J);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      Reset = e.rst; op = e.op; funct = e.funct; zero = e.zero;
      @(negedge CLK);
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL jump op=%b funct=%b: got %b expected %b", e.op, e.funct, obs, e.exp);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_nop();
    entry_t e;
    push(1'b0, 6'b110011, 6'b0, 1'b0, 2'b10, S_ADD, C_IF);
    push(1'b0, 6'b110011, 6'b0, 1'b0, 2'b10, S_ADD, C_PC4);
    push(1'b0, 6'b000000, 6'b111111, 1'b0, 2'b10, S_ADD, C_IF);
    push(1'b0, 6'b000000, 6'b111111, 1'b0, 2'b10, S_ADD, C_PC4);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      Reset = e.rst; op = e.op; funct = e.funct; zero = e.zero;
      @(negedge CLK);
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL nop op=%b funct=%b: got %b expected %b", e.op, e.funct, obs, e.exp);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_halt();
    entry_t e;
    push(1'b0, 6'b111111, 6'b0, 1'b0, 2'b10, S_ADD, C_IF);
    push(1'b0, 6'b111111, 6'b0, 1'b0, 2'b10, S_ADD, C_IDLE);
    // Changing op while halted must not release the machine.
    for (int i = 0; i < 10; i++)
      push(1'b0, (i < 5) ? 6'b111111 : 6'b000010, 6'b0, 1'b0, 2'b10, S_ADD, C_IDLE);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      Reset = e.rst; op = e.op; funct = e.funct; zero = e.zero;
      @(negedge CLK);
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL halt op=%b: got %b expected %b", e.op, obs, e.exp);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mid_sw();
    entry_t e;
    push(1'b1, 6'b101011, 6'b0, 1'b0, 2'b00, 5'b0, C_IDLE);
    push(1'b0, 6'b101011, 6'b0, 1'b0, 2'b10, S_LS, C_IF);
    push(1'b0, 6'b101011, 6'b0, 1'b0, 2'b10, S_LS, C_IDLE);
    push(1'b0, 6'b101011, 6'b0, 1'b0, 2'b10, S_LS, C_IDLE);
    push(1'b1, 6'b101011, 6'b0, 1'b0, 2'b00, 5'b0, C_IDLE);
    push(1'b0, 6'b101011, 6'b0, 1'b0, 2'b10, S_LS, C_IF);
    push(1'b0, 6'b101011, 6'b0, 1'b0, 2'b10, S_LS, C_IDLE);
    push(1'b0, 6'b101011, 6'b0, 1'b0, 2'b10, S_LS, C_IDLE);
    push(1'b0, 6'b101011, 6'b0, 1'b0, 2'b10, S_LS, C_WR);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      Reset = e.rst; op = e.op; funct = e.funct; zero = e.zero;
      @(negedge CLK);
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL reset_mid_sw rst=%b: got %b expected %b", e.rst, obs, e.exp);
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_beq();
    test_jumps();
    test_nop();
    test_halt();
    test_reset_mid_sw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
